// File: rtl/seg7_pkg.sv
// seg7_pkg: shared state type, nibble width and leading-zero helper for the scan controller
package seg7_pkg;
  localparam int NIBBLE_W = 4;
  localparam int MAX_DIGITS = 16;
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} scan_state_e;
  function automatic logic [MAX_DIGITS-1:0] lz_mask(input logic [NIBBLE_W*MAX_DIGITS-1:0] v, input int n, input logic en);
    logic z;
    z = 1'b1;
    lz_mask = '0;
    for (int i = MAX_DIGITS - 1; i > 0; i--)
      if (i < n) begin
        z = z & (v[i*NIBBLE_W +: NIBBLE_W] == '0);
        lz_mask[i] = en & z;
      end
  endfunction
endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if: valid/ready handshake carrying the packed display value
interface seg7_scan_ctrl_if import seg7_pkg::*; #(parameter int NUM_DIGITS = 4);
  logic [NIBBLE_W*NUM_DIGITS-1:0] value_in;
  logic value_valid;
  logic value_ready;
  modport master (output value_in, value_valid, input value_ready);
  modport slave (input value_in, value_valid, output value_ready);
endinterface

// File: rtl/seg7_slot_timer.sv
// seg7_slot_timer: per-slot cycle counter with blank and slot terminal-count flags
module seg7_slot_timer #(
  parameter int PRESCALE = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic blank_done,
  output logic slot_done
);
  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLAST = CW'(BLANK_CYC == 0 ? 0 : BLANK_CYC - 1);
  logic [CW-1:0] cnt;
  assign slot_done = cnt == LAST;
  assign blank_done = BLANK_CYC == 0 || cnt == BLAST;
  always_ff @(posedge clk)
    cnt <= (!rst_n || !run || slot_done) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed digit scanner with double-buffered value and leading-zero blanking
module seg7_scan_ctrl import seg7_pkg::*; #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE = 1000,
  parameter int BLANK_CYC = 16,
  parameter bit DIGIT_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  lz_blank_en,
  seg7_scan_ctrl_if.slave       vin,
  output logic [NIBBLE_W-1:0]   digit_code,
  output logic                  seg_blank,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic                  frame_tick
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{DIGIT_ACTIVE_LOW}};
  scan_state_e state, nxt_state;
  logic [IW-1:0] idx, nxt_idx;
  logic [NIBBLE_W*NUM_DIGITS-1:0] disp, shadow, nxt_disp;
  logic [NIBBLE_W*MAX_DIGITS-1:0] disp_ext;
  logic [MAX_DIGITS-1:0] lzm;
  logic [NUM_DIGITS-1:0] nxt_sel;
  logic [NIBBLE_W-1:0] nib [NUM_DIGITS];
  logic pending, nxt_pending, blank_done, slot_done, frame_end, commit, accept, nxt_tick;
  seg7_slot_timer #(.PRESCALE(PRESCALE), .BLANK_CYC(BLANK_CYC)) u_timer (
    .clk,
    .rst_n,
    .run(en && state != IDLE),
    .blank_done,
    .slot_done
  );
  // outputs are registered from next-state values so they line up with state, idx and display
  always_comb begin
    frame_end = state == SHOW && slot_done && idx == LAST_IDX;
    commit = pending && (state == IDLE || frame_end);
    accept = vin.value_valid && !pending;
    nxt_pending = !commit && (pending || accept);
    nxt_tick = en && (state == IDLE || frame_end);
    nxt_state = !en ? IDLE :
                state == IDLE ? (BLANK_CYC == 0 ? SHOW : BLANK) :
                state == BLANK ? (blank_done ? SHOW : BLANK) :
                (slot_done && BLANK_CYC != 0) ? BLANK : SHOW;
    nxt_idx = (!en || state == IDLE) ? '0 :
              (state == SHOW && slot_done) ? (idx == LAST_IDX ? '0 : idx + 1'b1) : idx;
    nxt_disp = commit ? shadow : disp;
    disp_ext = '0;
    disp_ext[NIBBLE_W*NUM_DIGITS-1:0] = nxt_disp;
    lzm = lz_mask(disp_ext, NUM_DIGITS, lz_blank_en);
    for (int i = 0; i < NUM_DIGITS; i++) nib[i] = nxt_disp[i*NIBBLE_W +: NIBBLE_W];
    nxt_sel = nxt_state == SHOW ? NUM_DIGITS'(1) << nxt_idx : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      disp <= '0;
      shadow <= '0;
      pending <= 1'b0;
      vin.value_ready <= 1'b1;
      digit_sel <= SEL_OFF;
      digit_code <= '0;
      seg_blank <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      state <= nxt_state;
      idx <= nxt_idx;
      disp <= nxt_disp;
      if (accept) shadow <= vin.value_in;
      pending <= nxt_pending;
      vin.value_ready <= !nxt_pending;
      digit_sel <= SEL_OFF ^ nxt_sel;
      digit_code <= nib[nxt_idx];
      seg_blank <= nxt_state != SHOW || lzm[nxt_idx];
      frame_tick <= nxt_tick;
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed stimulus with a frame-level reference model checked every cycle
module tb_seg7_scan_ctrl;
  localparam int N = 4, P = 8, B = 2, F = N * P;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, lz = 1'b0;
  logic [3:0] code;
  logic blank, tick;
  logic [N-1:0] sel;
  seg7_scan_ctrl_if #(.NUM_DIGITS(N)) vif();
  seg7_scan_ctrl #(.NUM_DIGITS(N), .PRESCALE(P), .BLANK_CYC(B), .DIGIT_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .lz_blank_en(lz), .vin(vif),
    .digit_code(code), .seg_blank(blank), .digit_sel(sel), .frame_tick(tick)
  );
  always #5 clk = ~clk;
  int pass = 0, total = 0;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
  endtask
  // model: t = cycles since the scan was (re)enabled, -1 while off
  int t = -1;
  logic [15:0] m_disp = '0, m_shadow = '0;
  bit m_pend = 1'b0, m_lz = 1'b0, mvalid = 1'b0;
  always @(posedge clk) begin : mdl
    int nt;
    logic [15:0] nd, ns;
    bit np;
    nt = t; nd = m_disp; ns = m_shadow; np = m_pend;
    if (!rst_n) begin
      nt = -1; nd = '0; ns = '0; np = 1'b0;
    end else begin
      if (np && (t < 0 || t % F == F - 1)) begin nd = ns; np = 1'b0; end
      else if (vif.value_valid && !np) begin ns = vif.value_in; np = 1'b1; end
      nt = en ? t + 1 : -1;
    end
    t <= nt; m_disp <= nd; m_shadow <= ns; m_pend <= np;
    m_lz <= lz; mvalid <= 1'b1;
  end
  always @(negedge clk) begin : cmp
    int di;
    bit on, show;
    if (mvalid) begin
      on = t >= 0;
      di = on ? (t / P) % N : 0;
      show = on && (t % P) >= B;
      chk("model_sel", 32'(sel), show ? 32'(1 << di) : 32'd0);
      chk("model_blank", 32'(blank), 32'(!show || (m_lz && di != 0 && (m_disp >> (4 * di)) == 0)));
      chk("model_tick", 32'(tick), 32'(on && t % F == 0));
      chk("model_ready", 32'(vif.value_ready), 32'(!m_pend));
      if (on) chk("model_code", 32'(code), 32'((m_disp >> (4 * di)) & 16'hF));
    end
  end
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic offer(input logic [15:0] v);
    vif.value_in = v;
    vif.value_valid = 1'b1;
    step(1);
    vif.value_valid = 1'b0;
  endtask
  initial begin
    vif.value_in = '0;
    vif.value_valid = 1'b0;
    step(2);
    chk("rst_sel", 32'(sel), 0); chk("rst_blank", 32'(blank), 1); chk("rst_code", 32'(code), 0);
    chk("rst_tick", 32'(tick), 0); chk("rst_ready", 32'(vif.value_ready), 1);
    rst_n = 1'b1;
    offer(16'h1234);
    chk("accept_ready", 32'(vif.value_ready), 0);
    step(1); chk("idle_commit_ready", 32'(vif.value_ready), 1);
    en = 1'b1;
    step(1); chk("t0_tick", 32'(tick), 1); chk("t0_sel", 32'(sel), 0); chk("t0_blank", 32'(blank), 1); chk("t0_code", 32'(code), 4);
    step(2); chk("t2_sel", 32'(sel), 4'b0001); chk("t2_code", 32'(code), 4); chk("t2_blank", 32'(blank), 0);
    step(8); chk("t10_sel", 32'(sel), 4'b0010); chk("t10_code", 32'(code), 3);
    step(16); chk("t26_sel", 32'(sel), 4'b1000); chk("t26_code", 32'(code), 1);
    step(6); chk("t32_tick", 32'(tick), 1);
    step(4); offer(16'h5678);
    chk("mid_ready", 32'(vif.value_ready), 0);
    step(5); chk("no_tear_code", 32'(code), 3);
    step(21); chk("t63_ready", 32'(vif.value_ready), 0);
    step(1); chk("t64_tick", 32'(tick), 1); chk("t64_ready", 32'(vif.value_ready), 1); chk("t64_code", 32'(code), 8);
    step(2); chk("t66_code", 32'(code), 8);
    step(8); chk("t74_code", 32'(code), 7);
    lz = 1'b1; offer(16'h0070);
    step(21); step(2); chk("lz_d0_blank", 32'(blank), 0); chk("lz_d0_code", 32'(code), 0);
    step(8); chk("lz_d1_blank", 32'(blank), 0); chk("lz_d1_code", 32'(code), 7);
    step(8); chk("lz_d2_blank", 32'(blank), 1); chk("lz_d2_sel", 32'(sel), 4'b0100);
    step(8); chk("lz_d3_blank", 32'(blank), 1);
    offer(16'h0000);
    step(5); step(2); chk("lz0_d0_blank", 32'(blank), 0);
    step(8); chk("lz0_d1_blank", 32'(blank), 1);
    step(16); chk("lz0_d3_blank", 32'(blank), 1);
    lz = 1'b0; offer(16'h1234);
    step(18); chk("t173_sel", 32'(sel), 4'b0010); chk("t173_code", 32'(code), 3);
    en = 1'b0;
    step(1); chk("off_sel", 32'(sel), 0); chk("off_blank", 32'(blank), 1); chk("off_tick", 32'(tick), 0);
    step(3); en = 1'b1;
    step(1); chk("reen_tick", 32'(tick), 1); chk("reen_sel", 32'(sel), 0); chk("reen_code", 32'(code), 4);
    step(2); chk("reen_show", 32'(sel), 4'b0001);
    en = 1'b0; step(2); offer(16'h9ABC);
    chk("off_accept_ready", 32'(vif.value_ready), 0);
    step(1); chk("off_commit_ready", 32'(vif.value_ready), 1);
    en = 1'b1;
    step(1); chk("c_tick", 32'(tick), 1); chk("c_code0", 32'(code), 4'hC);
    step(2); chk("c_sel0", 32'(sel), 4'b0001); chk("c_code0s", 32'(code), 4'hC);
    step(8); chk("c_code1", 32'(code), 4'hB);
    step(8); chk("c_code2", 32'(code), 4'hA);
    step(8); chk("c_code3", 32'(code), 4'h9); chk("c_sel3", 32'(sel), 4'b1000);
    step(8); offer(16'h1357);
    chk("pre_rst_ready", 32'(vif.value_ready), 0);
    rst_n = 1'b0;
    step(1); chk("mrst_sel", 32'(sel), 0); chk("mrst_blank", 32'(blank), 1); chk("mrst_code", 32'(code), 0);
    chk("mrst_tick", 32'(tick), 0); chk("mrst_ready", 32'(vif.value_ready), 1);
    rst_n = 1'b1;
    step(1); chk("post_tick", 32'(tick), 1); chk("post_code", 32'(code), 0);
    step(2); chk("post_sel0", 32'(sel), 4'b0001); chk("post_code0", 32'(code), 0);
    step(8); chk("post_code1", 32'(code), 0);
    step(30);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
